// File: rtl/alu_cmd_sequencer.sv
// Purpose : in-order issue stage and result collector around a fixed-latency ALU.
// Latency : accept at end of cycle 0 -> alu_issue in cycle 1 -> out_valid in cycle 2+ALU_LAT.
// Backpressure: in_ready drops when the command FIFO is full; issue stalls at zero credits,
//               so the result FIFO can never overflow while out_ready is low.
//
// Ports:
//   clk, reset (async, active-low)
//   in_valid/in_ready/in_a/in_b/in_op          command sink (valid/ready)
//   alu_a/alu_b/alu_op/alu_issue               registered command to the ALU
//   alu_result                                 ALU result, ALU_LAT cycles after alu_issue
//   out_valid/out_ready/out_result/out_op      result source (valid/ready)
//   busy                                       anything queued, in flight or unread

// Small synchronous FIFO used for both the command and the result queue.
// Latency: head visible the cycle after push. Backpressure: caller must honour full/empty.
// Storage is not reset; the occupancy counter alone defines validity.
module alu_cmd_seq_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Push into a full FIFO is legal when the head pops on the same edge:
    // the slot written is the one being vacated.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
endmodule

module alu_cmd_sequencer #(
    parameter int WIDTH     = 8,
    parameter int OP_W      = 3,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int ALU_LAT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OP_W-1:0]  alu_op,
    output logic             alu_issue,
    input  logic [WIDTH-1:0] alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [OP_W-1:0]  out_op,
    output logic             busy
);
    localparam int CRW = $clog2(RES_DEPTH + 1);

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [WIDTH-1:0] result;
    } res_t;

    cmd_t            in_cmd;
    cmd_t            head_cmd;
    cmd_t            issue_cmd;
    res_t            cap_res;
    res_t            head_res;
    logic            cmd_full;
    logic            cmd_empty;
    logic            cmd_push;
    logic            cmd_pop;
    logic            res_full;
    logic            res_empty;
    logic            res_push;
    logic            res_pop;
    logic            accept;
    logic            issue;
    logic            run;
    logic [CRW-1:0]  credits;
    logic [ALU_LAT-1:0] pipe_vld;
    logic [OP_W-1:0]    pipe_op [ALU_LAT];

    // run holds in_ready low while reset is asserted and releases it on the first edge after.
    assign in_ready = run && !cmd_full;
    assign accept   = in_valid && in_ready;
    assign in_cmd   = '{op: in_op, a: in_a, b: in_b};

    // An empty command FIFO lets the arriving command issue on its accept edge,
    // which is what gives alu_issue in the cycle straight after acceptance.
    assign issue     = (!cmd_empty || accept) && (credits != '0);
    assign issue_cmd = cmd_empty ? in_cmd : head_cmd;
    assign cmd_pop   = issue && !cmd_empty;
    assign cmd_push  = accept && !(issue && cmd_empty);

    alu_cmd_seq_fifo #(.W($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (cmd_push),
        .push_dat (in_cmd),
        .pop      (cmd_pop),
        .head_dat (head_cmd),
        .full     (cmd_full),
        .empty    (cmd_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run       <= 1'b0;
            alu_issue <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            credits   <= CRW'(RES_DEPTH);
        end else begin
            run       <= 1'b1;
            alu_issue <= issue;
            if (issue) begin
                alu_a  <= issue_cmd.a;
                alu_b  <= issue_cmd.b;
                alu_op <= issue_cmd.op;
            end
            // One credit per result FIFO slot: taken at issue, returned when the result leaves.
            case ({issue, res_pop})
                2'b10:   credits <= credits - CRW'(1);
                2'b01:   credits <= credits + CRW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Latency pipe tracks which cycle's alu_result belongs to an issued command, and its op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < ALU_LAT; i++) pipe_op[i] <= '0;
        end else begin
            pipe_vld[0] <= alu_issue;
            pipe_op[0]  <= alu_op;
            for (int i = 1; i < ALU_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_op[i]  <= pipe_op[i-1];
            end
        end
    end

    assign res_push = pipe_vld[ALU_LAT-1];
    assign cap_res  = '{op: pipe_op[ALU_LAT-1], result: alu_result};
    assign res_pop  = out_valid && out_ready;

    alu_cmd_seq_fifo #(.W($bits(res_t)), .DEPTH(RES_DEPTH)) u_res_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (res_push),
        .push_dat (cap_res),
        .pop      (res_pop),
        .head_dat (head_res),
        .full     (res_full),
        .empty    (res_empty)
    );

    assign out_valid  = !res_empty;
    // Storage is unreset, so mask the head while empty to keep the outputs at zero.
    assign out_result = res_empty ? '0 : head_res.result;
    assign out_op     = res_empty ? '0 : head_res.op;

    // The command sitting on alu_* is in flight as well, even before it enters the pipe.
    assign busy = !cmd_empty || alu_issue || (|pipe_vld) || !res_empty;

    // Credits guarantee a free slot for every capture; res_full is kept only for observability.
    logic unused_res_full;
    assign unused_res_full = res_full;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
    localparam int WIDTH     = 8;
    localparam int OP_W      = 3;
    localparam int CMD_DEPTH = 4;
    localparam int RES_DEPTH = 4;
    localparam int ALU_LAT   = 1;

    typedef logic [OP_W+WIDTH-1:0] ent_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [OP_W-1:0]  in_op = '0;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OP_W-1:0]  alu_op;
    logic             alu_issue;
    logic [WIDTH-1:0] alu_result = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic [OP_W-1:0]  out_op;
    logic             busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   issue_cnt = 0;
    ent_t exp_q[$];
    ent_t got_q[$];
    int   got_cyc[$];

    alu_cmd_sequencer #(
        .WIDTH(WIDTH), .OP_W(OP_W), .CMD_DEPTH(CMD_DEPTH),
        .RES_DEPTH(RES_DEPTH), .ALU_LAT(ALU_LAT)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_issue(alu_issue),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_op(out_op),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Stub ALU: registered adder.
    always @(posedge clk) alu_result <= alu_a + alu_b;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: every accepted command yields (A+B) mod 256 tagged with its op,
    // delivered in acceptance order.
    function automatic ent_t ref_entry(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic [OP_W-1:0] op);
        int sum;
        sum = (int'(a) + int'(b)) % 256;
        return {op, WIDTH'(sum)};
    endfunction

    // Handshakes complete on the next rising edge; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (in_valid && in_ready) exp_q.push_back(ref_entry(in_a, in_b, in_op));
        if (out_valid && out_ready) begin
            got_q.push_back({out_op, out_result});
            got_cyc.push_back(cyc);
        end
        if (alu_issue) issue_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        exp_q.delete();
        got_q.delete();
        got_cyc.delete();
        issue_cnt = 0;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [OP_W-1:0] op);
        bit ok;
        ok = 1'b0;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        tick();
        in_valid = 1'b0;
        if (!ok) begin
            checks++; failures++;
            $display("FAIL send_timeout: in_ready never high, got 0 required 1");
        end
    endtask

    task automatic wait_results(input int n, input int budget);
        for (int t = 0; t < budget && got_q.size() < n; t++) tick();
    endtask

    task automatic test_reset();
        logic [35:0] outs;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        outs = {in_ready, alu_issue, alu_a, alu_b, alu_op, out_valid, out_result, out_op, busy};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            failures++;
            $display("FAIL reset_release: got rdy/busy/vld=%b required 100", {in_ready, busy, out_valid});
        end
    endtask

    task automatic test_single_op();
        tick();
        clear_obs();
        out_ready = 1'b1;
        in_a = 8'h12; in_b = 8'h34; in_op = 3'd0; in_valid = 1'b1;
        @(negedge clk);   // cycle 0
        checks++;
        if ({in_ready, alu_issue} !== 2'b10) begin
            failures++;
            $display("FAIL single_cyc0: got rdy/issue=%b required 10", {in_ready, alu_issue});
        end
        tick(); in_valid = 1'b0;
        @(negedge clk);   // cycle 1
        checks++;
        if ({alu_issue, alu_a, alu_b, alu_op, out_valid} !== {1'b1, 8'h12, 8'h34, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL single_issue: got issue=%b a=%h b=%h op=%0d vld=%b required 1 12 34 0 0",
                     alu_issue, alu_a, alu_b, alu_op, out_valid);
        end
        tick();
        @(negedge clk);   // cycle 2
        checks++;
        if ({alu_issue, alu_a, alu_b, out_valid, busy} !== {1'b0, 8'h12, 8'h34, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL single_hold: got issue=%b a=%h b=%h vld=%b busy=%b required 0 12 34 0 1",
                     alu_issue, alu_a, alu_b, out_valid, busy);
        end
        tick();
        @(negedge clk);   // cycle 3
        checks++;
        if ({out_valid, out_result, out_op} !== {1'b1, 8'h46, 3'd0}) begin
            failures++;
            $display("FAIL single_result: got vld=%b res=%h op=%0d required 1 46 0",
                     out_valid, out_result, out_op);
        end
        tick();
        @(negedge clk);   // cycle 4
        checks++;
        if ({out_valid, busy} !== 2'b00 || got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            failures++;
            $display("FAIL single_done: got vld=%b busy=%b results=%0d required 0 0 1 matching model",
                     out_valid, busy, got_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [OP_W-1:0] op;
        int bad;
        tick();
        clear_obs();
        out_ready = 1'b1;
        op = OP_W'($urandom);
        send(8'hF0, 8'h20, op);
        send(8'hFF, 8'h01, 3'd7);
        send(8'hFF, 8'hFF, 3'd2);
        for (int i = 0; i < 6; i++) send(8'($urandom), 8'($urandom), OP_W'($urandom));
        wait_results(9, 60);
        checks++;
        if (got_q.size() != 9 || got_q[0] !== {op, 8'h10} || got_q[1] !== {3'd7, 8'h00} || got_q[2] !== {3'd2, 8'hFE}) begin
            failures++;
            $display("FAIL wrap_sum: got n=%0d first=%h required n=9 first=%h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : ent_t'(0), {op, 8'h10});
        end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0 || exp_q.size() != got_q.size()) begin
            failures++;
            $display("FAIL random_ops: got %0d mismatches over %0d results required 0 over %0d", bad, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_back_pressure();
        int rdy_seen;
        bit ok;
        tick();
        clear_obs();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(8'(i), 8'h01, OP_W'($urandom));
        repeat (4) tick();
        @(negedge clk);
        checks++;
        if (issue_cnt != RES_DEPTH || in_ready !== 1'b0 || exp_q.size() != 8) begin
            failures++;
            $display("FAIL bp_fill: got issued=%0d rdy=%b accepted=%0d required %0d 0 8",
                     issue_cnt, in_ready, exp_q.size(), RES_DEPTH);
        end
        checks++;
        if ({out_valid, out_result} !== {1'b1, 8'h01}) begin
            failures++;
            $display("FAIL bp_head: got vld=%b res=%h required 1 01", out_valid, out_result);
        end
        // Ninth command is offered while the queue is full and must wait.
        tick();
        in_a = 8'h08; in_b = 8'h01; in_op = OP_W'($urandom); in_valid = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready || out_result !== 8'h01) rdy_seen++;
        end
        checks++;
        if (rdy_seen != 0 || exp_q.size() != 8 || issue_cnt != RES_DEPTH) begin
            failures++;
            $display("FAIL bp_stall: got rdy_or_head_changes=%0d accepted=%0d issued=%0d required 0 8 %0d",
                     rdy_seen, exp_q.size(), issue_cnt, RES_DEPTH);
        end
        tick();
        out_ready = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_ninth_accept: got in_ready=0 required 1");
        end
        wait_results(9, 100);
        repeat (5) tick();
        checks++;
        if (got_q.size() != 9 || exp_q.size() != 9) begin
            failures++;
            $display("FAIL bp_count: got %0d results %0d accepted required 9 9", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 9; i++) begin
            checks++;
            if (got_q[i][WIDTH-1:0] !== 8'(i + 1) || got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL bp_order[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_streaming();
        int c0;
        int stalls;
        int bad;
        tick();
        clear_obs();
        out_ready = 1'b1;
        c0 = cyc;
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            in_a = 8'($urandom); in_b = 8'($urandom); in_op = OP_W'($urandom); in_valid = 1'b1;
            @(negedge clk);
            if (!in_ready) stalls++;
            tick();
        end
        in_valid = 1'b0;
        wait_results(20, 60);
        checks++;
        if (stalls != 0 || got_q.size() != 20 || issue_cnt != 20) begin
            failures++;
            $display("FAIL stream_count: got stalls=%0d results=%0d issued=%0d required 0 20 20",
                     stalls, got_q.size(), issue_cnt);
        end
        checks++;
        if (got_cyc.size() != 20 || got_cyc[0] != c0 + 3 || got_cyc[19] != c0 + 22) begin
            failures++;
            $display("FAIL stream_timing: got first=%0d last=%0d required %0d %0d",
                     (got_cyc.size() > 0) ? got_cyc[0] - c0 : -1,
                     (got_cyc.size() > 19) ? got_cyc[19] - c0 : -1, 3, 22);
        end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL stream_data: got %0d mismatches required 0", bad);
        end
    endtask

    task automatic test_back_to_back_full();
        int c1;
        int bad;
        tick();
        clear_obs();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(8'($urandom), 8'($urandom), OP_W'($urandom));
        repeat (4) tick();
        @(negedge clk);
        checks++;
        if (issue_cnt != RES_DEPTH || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_setup: got issued=%0d vld=%b rdy=%b required %0d 1 1",
                     issue_cnt, out_valid, in_ready, RES_DEPTH);
        end
        tick();
        out_ready = 1'b1;
        c1 = cyc;
        wait_results(6, 40);
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i] || got_cyc[i] != c1 + i) bad++;
        checks++;
        if (bad != 0 || got_q.size() != 6) begin
            failures++;
            $display("FAIL full_drain: got %0d bad of %0d results required 0 of 6", bad, got_q.size());
        end
    endtask

    task automatic test_reset_mid_flight();
        logic [35:0] outs;
        tick();
        clear_obs();
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send(8'($urandom), 8'($urandom), OP_W'($urandom));
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        #1;
        checks++;
        if ({alu_issue, busy, out_valid, in_ready} !== 4'b1111) begin
            failures++;
            $display("FAIL midflight_setup: got issue/busy/vld/rdy=%b required 1111",
                     {alu_issue, busy, out_valid, in_ready});
        end
        reset = 1'b0;
        #1;
        outs = {in_ready, alu_issue, alu_a, alu_b, alu_op, out_valid, out_result, out_op, busy};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL midflight_async: got %h required 0", outs);
        end
        repeat (2) tick();
        clear_obs();
        @(negedge clk);
        reset = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            failures++;
            $display("FAIL midflight_release: got rdy/busy/vld=%b required 100", {in_ready, busy, out_valid});
        end
        out_ready = 1'b1;
        repeat (10) tick();
        checks++;
        if (got_q.size() != 0 || issue_cnt != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midflight_stale: got results=%0d issued=%0d busy=%b required 0 0 0",
                     got_q.size(), issue_cnt, busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_wrap();
        test_back_pressure();
        test_streaming();
        test_back_to_back_full();
        test_reset_mid_flight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
